// File: rtl/calc_unit_sequencer.sv
// Address/control sequencer for a pixel-by-input-channel calc unit.
// Issues buffer reads, aligns control with read data and result write-back.
module calc_unit_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 12,
   parameter int RD_LAT     = 1,
   parameter int CALC_LAT   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_pix,
   input  logic [CNT_WIDTH-1:0]  num_ic,
   input  logic                  hold,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] in_buf_raddr,
   output logic [ADDR_WIDTH-1:0] kn_buf_raddr,
   output logic                  calc_en,
   output logic                  calc_reset,
   output logic                  calc_we,
   output logic                  out_buf_we,
   output logic [ADDR_WIDTH-1:0] out_buf_waddr
);

   localparam int DRAIN_LEN = RD_LAT + CALC_LAT;
   localparam int DW        = $clog2(DRAIN_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_num_pix;
   logic [CNT_WIDTH-1:0]  r_num_ic;
   logic [CNT_WIDTH-1:0]  r_pix;
   logic [CNT_WIDTH-1:0]  r_ic;
   logic [ADDR_WIDTH-1:0] r_in_addr;
   logic [DW-1:0]         r_drain_cnt;
   logic                  r_busy;
   logic                  r_done;

   logic [RD_LAT-1:0]     r_rd_en;
   logic [RD_LAT-1:0]     r_rd_first;
   logic [RD_LAT-1:0]     r_rd_last;
   logic [CNT_WIDTH-1:0]  r_rd_pix [RD_LAT];
   logic [CALC_LAT-1:0]   r_ca_we;
   logic [CNT_WIDTH-1:0]  r_ca_pix [CALC_LAT];

   logic w_issue;
   logic w_ic_last;
   logic w_pix_last;

   assign w_issue    = (r_state == S_RUN) && !hold;
   assign w_ic_last  = (r_ic == r_num_ic - CNT_WIDTH'(1));
   assign w_pix_last = (r_pix == r_num_pix - CNT_WIDTH'(1));

   // in_buf address is pix*num_ic+ic; issue order makes that a plain increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_num_pix   <= '0;
         r_num_ic    <= '0;
         r_pix       <= '0;
         r_ic        <= '0;
         r_in_addr   <= '0;
         r_drain_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_num_pix <= num_pix;
                  r_num_ic  <= num_ic;
                  r_pix     <= '0;
                  r_ic      <= '0;
                  r_in_addr <= '0;
                  r_busy    <= 1'b1;
                  if (num_pix == '0 || num_ic == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (!hold) begin
                  if (w_ic_last && w_pix_last) begin
                     r_state     <= S_DRAIN;
                     r_drain_cnt <= '0;
                  end else begin
                     r_in_addr <= r_in_addr + ADDR_WIDTH'(1);
                     if (w_ic_last) begin
                        r_ic  <= '0;
                        r_pix <= r_pix + CNT_WIDTH'(1);
                     end else begin
                        r_ic <= r_ic + CNT_WIDTH'(1);
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == DW'(DRAIN_LEN - 1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_en    <= '0;
         r_rd_first <= '0;
         r_rd_last  <= '0;
         r_ca_we    <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) r_rd_pix[i] <= '0;
         for (int unsigned i = 0; i < CALC_LAT; i++) r_ca_pix[i] <= '0;
      end else begin
         r_rd_en[0]    <= w_issue;
         r_rd_first[0] <= w_issue && (r_ic == '0);
         r_rd_last[0]  <= w_issue && w_ic_last;
         r_rd_pix[0]   <= r_pix;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_rd_en[i]    <= r_rd_en[i-1];
            r_rd_first[i] <= r_rd_first[i-1];
            r_rd_last[i]  <= r_rd_last[i-1];
            r_rd_pix[i]   <= r_rd_pix[i-1];
         end
         r_ca_we[0]  <= r_rd_last[RD_LAT-1];
         r_ca_pix[0] <= r_rd_pix[RD_LAT-1];
         for (int unsigned i = 1; i < CALC_LAT; i++) begin
            r_ca_we[i]  <= r_ca_we[i-1];
            r_ca_pix[i] <= r_ca_pix[i-1];
         end
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign in_buf_raddr  = r_in_addr;
   assign kn_buf_raddr  = ADDR_WIDTH'(r_ic);
   assign calc_en       = r_rd_en[RD_LAT-1];
   assign calc_reset    = r_rd_first[RD_LAT-1];
   assign calc_we       = r_rd_last[RD_LAT-1];
   assign out_buf_we    = r_ca_we[CALC_LAT-1];
   assign out_buf_waddr = ADDR_WIDTH'(r_ca_pix[CALC_LAT-1]);

endmodule

// File: tb/tb_calc_unit_sequencer.sv
// Scoreboard bench for calc_unit_sequencer: stimulus pushes expected words,
// write-backs and done pulses; a negedge monitor pops and compares.
module tb_calc_unit_sequencer;

   localparam int AW  = 16;
   localparam int CW  = 12;
   localparam int RDL = 1;
   localparam int CAL = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] num_pix;
   logic [CW-1:0] num_ic;
   logic          hold;
   logic          busy;
   logic          done;
   logic [AW-1:0] in_buf_raddr;
   logic [AW-1:0] kn_buf_raddr;
   logic          calc_en;
   logic          calc_reset;
   logic          calc_we;
   logic          out_buf_we;
   logic [AW-1:0] out_buf_waddr;

   calc_unit_sequencer #(
      .ADDR_WIDTH(AW),
      .CNT_WIDTH (CW),
      .RD_LAT    (RDL),
      .CALC_LAT  (CAL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_pix      (num_pix),
      .num_ic       (num_ic),
      .hold         (hold),
      .busy         (busy),
      .done         (done),
      .in_buf_raddr (in_buf_raddr),
      .kn_buf_raddr (kn_buf_raddr),
      .calc_en      (calc_en),
      .calc_reset   (calc_reset),
      .calc_we      (calc_we),
      .out_buf_we   (out_buf_we),
      .out_buf_waddr(out_buf_waddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int in_a;
      int kn_a;
      bit fr;
      bit la;
   } word_t;

   typedef struct {
      int cyc;
      int addr;
   } wr_t;

   word_t q_word[$];
   wr_t   q_wr[$];
   int    q_done[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [AW-1:0] hist_in [16];
   logic [AW-1:0] hist_kn [16];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: addresses are remembered per cycle so a calc_en word can be
   // matched against the addresses issued RD_LAT cycles before it.
   always @(negedge clk) begin
      word_t w;
      wr_t   r;
      int    d;
      hist_in[cyc % 16] = in_buf_raddr;
      hist_kn[cyc % 16] = kn_buf_raddr;
      if (calc_en) begin
         if (q_word.size() == 0) chk("calc_en_unexpected", calc_en, 0);
         else begin
            w = q_word.pop_front();
            chk("calc_en_cycle", cyc, w.cyc);
            chk("in_buf_raddr", hist_in[(cyc - RDL) % 16], w.in_a);
            chk("kn_buf_raddr", hist_kn[(cyc - RDL) % 16], w.kn_a);
            chk("calc_reset", calc_reset, w.fr);
            chk("calc_we", calc_we, w.la);
         end
      end else if (calc_reset || calc_we) begin
         chk("ctrl_without_en", {30'd0, calc_reset, calc_we}, 0);
      end
      if (out_buf_we) begin
         if (q_wr.size() == 0) chk("out_buf_we_unexpected", out_buf_we, 0);
         else begin
            r = q_wr.pop_front();
            chk("out_buf_we_cycle", cyc, r.cyc);
            chk("out_buf_waddr", out_buf_waddr, r.addr);
         end
      end
      if (done) begin
         if (q_done.size() == 0) chk("done_unexpected", done, 0);
         else begin
            d = q_done.pop_front();
            chk("done_cycle", cyc, d);
            chk("busy_at_done", busy, 1);
         end
      end
   end

   // Expected response of a run whose start is sampled at edge s; words with
   // index >= hold_k are delayed by hold_len stall cycles.
   task automatic push_run(input int s, input int np, input int ni, input int hold_k, input int hold_len);
      word_t w;
      wr_t   r;
      int    iss;
      int    last_iss;
      if (np == 0 || ni == 0) begin
         q_done.push_back(s);
         return;
      end
      last_iss = s;
      for (int k = 0; k < np * ni; k++) begin
         iss = s + k + ((hold_k >= 0 && k >= hold_k) ? hold_len : 0);
         w.cyc  = iss + RDL;
         w.in_a = k;
         w.kn_a = k % ni;
         w.fr   = (k % ni == 0);
         w.la   = (k % ni == ni - 1);
         q_word.push_back(w);
         if (w.la) begin
            r.cyc  = iss + RDL + CAL;
            r.addr = k / ni;
            q_wr.push_back(r);
         end
         last_iss = iss;
      end
      q_done.push_back(last_iss + RDL + CAL + 1);
   endtask

   task automatic do_start(input int np, input int ni, output int s);
      @(posedge clk);
      #1;
      num_pix = CW'(np);
      num_ic  = CW'(ni);
      start   = 1'b1;
      s       = cyc + 1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_all();
      int left;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (q_word.size() == 0 && q_wr.size() == 0 && q_done.size() == 0) break;
      end
      left = q_word.size() + q_wr.size() + q_done.size();
      chk("timeout_pending", left, 0);
      q_word.delete();
      q_wr.delete();
      q_done.delete();
      #1;
      chk("busy_after_done", busy, 0);
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_calc_en"}, calc_en, 0);
      chk({tag, "_calc_reset"}, calc_reset, 0);
      chk({tag, "_calc_we"}, calc_we, 0);
      chk({tag, "_out_buf_we"}, out_buf_we, 0);
      chk({tag, "_in_buf_raddr"}, in_buf_raddr, 0);
      chk({tag, "_kn_buf_raddr"}, kn_buf_raddr, 0);
      chk({tag, "_out_buf_waddr"}, out_buf_waddr, 0);
   endtask

   initial begin
      int s;
      word_t w;
      rst = 1'b1; start = 1'b0; hold = 1'b0; num_pix = '0; num_ic = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // 2 pixels x 3 channels
      do_start(2, 3, s);
      push_run(s, 2, 3, -1, 0);
      wait_all();

      // single channel: reset and we on every word
      do_start(3, 1, s);
      push_run(s, 3, 1, -1, 0);
      wait_all();

      // 2-cycle hold after ic=1 has issued
      do_start(1, 4, s);
      push_run(s, 1, 4, 2, 2);
      repeat (2) @(posedge clk);
      #1 hold = 1'b1;
      repeat (2) @(posedge clk);
      #1 hold = 1'b0;
      wait_all();

      // zero counts go straight to DONE
      do_start(0, 5, s);
      push_run(s, 0, 5, -1, 0);
      wait_all();
      do_start(3, 0, s);
      push_run(s, 3, 0, -1, 0);
      wait_all();

      // async reset mid-run: only words whose calc_en precedes reset appear
      do_start(4, 3, s);
      for (int k = 0; k < 2; k++) begin
         w.cyc = s + k + RDL; w.in_a = k; w.kn_a = k; w.fr = (k == 0); w.la = 1'b0;
         q_word.push_back(w);
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("midrun_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      chk("post_reset_pending", q_word.size() + q_wr.size() + q_done.size(), 0);
      do_start(1, 2, s);
      push_run(s, 1, 2, -1, 0);
      wait_all();

      // start while busy is ignored; hold during DRAIN/DONE has no effect
      do_start(2, 2, s);
      push_run(s, 2, 2, -1, 0);
      @(posedge clk);
      #1;
      num_pix = CW'(5); num_ic = CW'(7); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 hold = 1'b1;
      wait_all();
      hold = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/calc_unit_sequencer.md
CALC_UNIT_SEQUENCER -- requirements
Module: calc_unit_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the width of all buffer addresses.
REQ-002 SHALL have parameter CNT_WIDTH, default 12, the width of the num_pix and num_ic counts.
REQ-003 SHALL have parameter RD_LAT, default 1, the in_buf/kn_buf read latency in cycles.
REQ-004 SHALL have parameter CALC_LAT, default 3, the cycles from calc_we to calc unit result valid.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a run.
- num_pix  in  CNT_WIDTH  pixel count, latched at start.
- num_ic  in  CNT_WIDTH  input-channel words per pixel, latched at start.
- hold  in  1  pause issue; no address advance while high.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- in_buf_raddr  out  ADDR_WIDTH  input-buffer read address.
- kn_buf_raddr  out  ADDR_WIDTH  kernel-buffer read address.
- calc_en  out  1  read data valid for the calc unit.
- calc_reset  out  1  first input-channel word of a pixel.
- calc_we  out  1  last input-channel word of a pixel.
- out_buf_we  out  1  write strobe for the calc result.
- out_buf_waddr  out  ADDR_WIDTH  output-buffer pixel address.

Function
REQ-007 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-008 IDLE: start=1 SHALL latch num_pix and num_ic, clear the pix and ic counters, set busy, and go to RUN; if either latched count is 0, SHALL go to DONE instead.
REQ-009 start SHALL be ignored in any state other than IDLE.
REQ-010 RUN: each cycle with hold=0 SHALL issue one read:
- in_buf_raddr = pix*num_ic + ic, kept as a running-sum register with no multiplier.
- kn_buf_raddr = ic.
- ic then increments; at ic=num_ic-1, ic wraps to 0 and pix increments.
REQ-011 RUN with hold=1 SHALL issue nothing, keep both addresses and counters unchanged, and produce calc_en=0 RD_LAT cycles later.
REQ-012 The issue of ic=num_ic-1, pix=num_pix-1 SHALL move RUN to DRAIN.
REQ-013 calc_en, calc_reset and calc_we SHALL be the issue-cycle values (valid, ic==0, ic==num_ic-1) delayed exactly RD_LAT cycles, so they align with rdata.
- calc_reset and calc_we are both asserted on the same word when num_ic=1.
- calc_reset and calc_we SHALL be 0 whenever calc_en=0.
REQ-014 out_buf_we SHALL equal calc_we delayed CALC_LAT cycles.
- out_buf_waddr SHALL be the pix of that word, delayed identically.
REQ-015 DRAIN SHALL last exactly RD_LAT+CALC_LAT cycles after the final issue, then go to DONE.
REQ-016 DONE SHALL assert done for one cycle, clear busy, and return to IDLE.
REQ-017 hold SHALL have no effect in DRAIN, DONE or IDLE.
- The delay pipelines always advance.
REQ-018 Counters and address SHALL be sized so that num_pix*num_ic ≤ 2^ADDR_WIDTH produces no wrap.
- Larger products wrap modulo 2^ADDR_WIDTH; they are unchecked.
REQ-019 Addresses SHALL hold their last value when not issuing.

Reset
REQ-020 rst=1 SHALL asynchronously force:
- state IDLE.
- All counters and delay pipelines 0.
- busy, done, calc_en, calc_reset, calc_we, out_buf_we = 0.
- All addresses 0.
REQ-021 rst asserted mid-run SHALL abort the run with no done pulse.
- After release, the block waits in IDLE for a new start.

Verification
REQ-022 Scenario: num_pix=2, num_ic=3, hold=0.
- in_buf_raddr issues 0,1,2,3,4,5; kn_buf_raddr issues 0,1,2,0,1,2.
- calc_reset is high on words 0 and 3; calc_we is high on words 2 and 5.
- out_buf_we pulses 2 times with waddr 0 then 1, each 4 cycles after its issue.
- done occurs 4 cycles after the last issue, plus 1 cycle for the DONE state.
REQ-023 Scenario: num_ic=1, num_pix=3.
- calc_reset and calc_we are high on every word.
- out_buf_waddr sequence is 0,1,2.
REQ-024 Scenario: hold=1 for 2 cycles during num_pix=1, num_ic=4, starting after ic=1.
- Addresses freeze.
- calc_en shows a 2-cycle gap.
- The results are otherwise identical to the no-hold run, shifted 2 cycles.
REQ-025 Scenario: start with num_pix=0.
- No calc_en or out_buf_we is produced.
- done pulses in the cycle after the start cycle.
REQ-026 Scenario: rst pulsed mid-RUN.
- All outputs read 0 immediately.
- No done pulse occurs.
- A new start then runs correctly from address 0.
REQ-027 Scenario: start asserted while busy.
- It is ignored; the latched counts do not change.
